// File: rtl/chstrip_pkg.sv
// Purpose: shared constants and types for the channel-strip front panel.
//   KPC_IDLE : keypad row/column value with nothing active (all high)
//   KPC_C0   : column drive for the first scan column
//   DIV_48K  : CLOCK_50 cycles per ~48 kHz tick (50 MHz / 1041)
//   col_t    : keypad scan column state
package chstrip_pkg;

  localparam logic [3:0]  KPC_IDLE = 4'b1111;
  localparam logic [3:0]  KPC_C0   = 4'b0111;
  localparam int unsigned DIV_48K  = 1041;

  typedef enum logic [1:0] {C0, C1, C2, C3} col_t;

  // Active-low one-hot column drive for a scan state.
  function automatic logic [3:0] col_to_kpc(input col_t c);
    logic [3:0] k;
    case (c)
      C0:      k = 4'b0111;
      C1:      k = 4'b1011;
      C2:      k = 4'b1101;
      C3:      k = 4'b1110;
      default: k = KPC_C0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/kp_scan_timebase_tick_gen.sv
// Purpose: free-running divider producing a one-cycle tick and a ~50% square wave.
// Ports:
//   CLOCK_50 in  : clock
//   reset    in  : asynchronous active-high reset
//   tick     out : registered 1-cycle pulse, high in the cycle after cnt==DIV-1
//   sq       out : registered square wave, high while cnt >= DIV/2
module tick_gen
  import chstrip_pkg::*;
#(
  parameter int unsigned DIV = DIV_48K
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick,
  output logic sq
);

  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, sq_q;

  // Next count, wrapping at DIV-1.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // sq is computed from cnt_d so the registered wave lines up with cnt_q.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == LAST);
      sq_q   <= (cnt_d >= HALF);
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/kp_scan_timebase.sv
// Purpose: ~48 kHz timebase, 4x4 keypad column scanner and display digit counter.
// Ports:
//   CLOCK_50 in      : sole clock
//   reset    in      : asynchronous active-high reset
//   kpr      in  [4] : keypad rows, active-low, asynchronous
//   tick_48  out     : one-cycle enable pulse every DIV cycles
//   clk_48   out     : registered square wave at tick rate (observation only)
//   kpc      out [4] : keypad column drive, one-hot active-low
//   digit    out [2] : current display digit index
//   ct       out [4] : digit enable, one-hot active-high, decoded from digit
module kp_scan_timebase
  import chstrip_pkg::*;
#(
  parameter int unsigned DIV = DIV_48K
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic       tick_48,
  output logic       clk_48,
  output logic [3:0] kpc,
  output logic [1:0] digit,
  output logic [3:0] ct
);

  logic [3:0] kpr_meta_q, kpr_sync_q;
  col_t       col_q, col_d;
  logic [3:0] kpc_q, kpc_d;
  logic [1:0] digit_q, digit_d;

  tick_gen #(.DIV(DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick_48),
    .sq       (clk_48)
  );

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      kpr_meta_q <= KPC_IDLE;
      kpr_sync_q <= KPC_IDLE;
    end else begin
      kpr_meta_q <= kpr;
      kpr_sync_q <= kpr_meta_q;
    end
  end

  // Scanner and digit state registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      col_q   <= C0;
      kpc_q   <= KPC_C0;
      digit_q <= 2'd0;
    end else begin
      col_q   <= col_d;
      kpc_q   <= kpc_d;
      digit_q <= digit_d;
    end
  end

  // Next state: advance on tick; a pressed key holds the column, digit always moves.
  always_comb begin
    col_d   = col_q;
    kpc_d   = kpc_q;
    digit_d = digit_q;
    if (tick_48) begin
      digit_d = digit_q + 2'd1;
      if (kpc_q != col_to_kpc(col_q)) begin
        // Column drive disagrees with the state (e.g. upset): restart the scan.
        col_d = C0;
      end else if (kpr_sync_q == KPC_IDLE) begin
        case (col_q)
          C0: col_d = C1;
          C1: col_d = C2;
          C2: col_d = C3;
          C3: col_d = C0;
        endcase
      end
      kpc_d = col_to_kpc(col_d);
    end
  end

  assign kpc   = kpc_q;
  assign digit = digit_q;
  assign ct    = 4'(4'b0001 << digit_q);

endmodule

// File: tb/tb_kp_scan_timebase.sv
// Bench for kp_scan_timebase: a DIV=1041 instance for tick/duty/reset timing and a
// DIV=4 instance for the scan sequence and key hold, with expected responses queued
// by the stimulus and consumed by monitors on each tick or clk_48 edge.
module tb_kp_scan_timebase;

  typedef struct packed {
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [1:0] digit;
    logic [3:0] ct;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [3:0] kpr1, kpr4;
  logic       tick1, clk1, tick4, clk4;
  logic [3:0] kpc1, ct1, kpc4, ct4;
  logic [1:0] digit1, digit4;

  int   checks   = 0;
  int   failures = 0;
  int   cyc1     = 0;
  bit   duty_en  = 1'b0;
  bit   done4    = 1'b0;

  int   tick_exp[$];
  int   edge_exp[$];
  vec_t q4[$];
  vec_t vec[17];

  always #5 clk = ~clk;

  kp_scan_timebase u_dut (
    .CLOCK_50 (clk),
    .reset    (rst1),
    .kpr      (kpr1),
    .tick_48  (tick1),
    .clk_48   (clk1),
    .kpc      (kpc1),
    .digit    (digit1),
    .ct       (ct1)
  );

  kp_scan_timebase #(.DIV(4)) u_dut4 (
    .CLOCK_50 (clk),
    .reset    (rst4),
    .kpr      (kpr4),
    .tick_48  (tick4),
    .clk_48   (clk4),
    .kpc      (kpc4),
    .digit    (digit4),
    .ct       (ct4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] k,
                              input logic [1:0] d, input logic [3:0] c);
    vec_t v;
    v.kpr = r; v.kpc = k; v.digit = d; v.ct = c;
    return v;
  endfunction

  // Cycles since reset release of the DIV=1041 instance.
  initial forever begin
    @(posedge clk);
    cyc1 = rst1 ? 0 : cyc1 + 1;
  end

  // Tick monitor, DIV=1041: arrival cycle and one-cycle width.
  initial begin
    bit prev_t = 1'b0;
    bit ok;
    forever begin
      @(negedge clk);
      if (prev_t) check("tick48_width", 32'(tick1), 32'd0);
      if (!rst1 && tick1) begin
        ok = (tick_exp.size() != 0);
        check("tick48_expected", 32'(ok), 32'd1);
        if (ok) check("tick48_cycle", 32'(cyc1), 32'(tick_exp.pop_front()));
      end
      prev_t = tick1;
    end
  end

  // clk_48 edge monitor, DIV=1041, first period only.
  initial begin
    bit prev_c = 1'b0;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst1 && duty_en && cyc1 <= 1600 && clk1 !== prev_c) begin
        ok = (edge_exp.size() != 0);
        check("clk48_edge_expected", 32'(ok), 32'd1);
        if (ok) check(clk1 ? "clk48_rise_cycle" : "clk48_fall_cycle",
                      32'(cyc1), 32'(edge_exp.pop_front()));
        if (clk1) check("clk48_rise_cnt", 32'(u_dut.u_tick.cnt_q), 32'd520);
      end
      prev_c = clk1;
    end
  end

  // Tick monitor, DIV=4: state after each tick against the queued vector.
  initial begin
    vec_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!rst4 && tick4) begin
        @(negedge clk);
        ok = (q4.size() != 0);
        check("dut4_expected", 32'(ok), 32'd1);
        if (ok) begin
          e = q4.pop_front();
          check("dut4_kpc",   32'(kpc4),   32'(e.kpc));
          check("dut4_digit", 32'(digit4), 32'(e.digit));
          check("dut4_ct",    32'(ct4),    32'(e.ct));
        end
      end
    end
  end

  // Stimulus, DIV=4: kpr before tick i and expected state after it.
  initial begin
    int n;
    vec[0]  = mk(4'hF, 4'b1011, 2'd1, 4'b0010);
    vec[1]  = mk(4'hF, 4'b1101, 2'd2, 4'b0100);
    vec[2]  = mk(4'hF, 4'b1110, 2'd3, 4'b1000);
    vec[3]  = mk(4'hF, 4'b0111, 2'd0, 4'b0001);
    vec[4]  = mk(4'hF, 4'b1011, 2'd1, 4'b0010);
    vec[5]  = mk(4'hD, 4'b1011, 2'd2, 4'b0100);
    vec[6]  = mk(4'hD, 4'b1011, 2'd3, 4'b1000);
    vec[7]  = mk(4'hD, 4'b1011, 2'd0, 4'b0001);
    vec[8]  = mk(4'hD, 4'b1011, 2'd1, 4'b0010);
    vec[9]  = mk(4'hD, 4'b1011, 2'd2, 4'b0100);
    vec[10] = mk(4'hD, 4'b1011, 2'd3, 4'b1000);
    vec[11] = mk(4'hD, 4'b1011, 2'd0, 4'b0001);
    vec[12] = mk(4'hD, 4'b1011, 2'd1, 4'b0010);
    vec[13] = mk(4'hD, 4'b1011, 2'd2, 4'b0100);
    vec[14] = mk(4'hD, 4'b1011, 2'd3, 4'b1000);
    vec[15] = mk(4'hF, 4'b1101, 2'd0, 4'b0001);
    vec[16] = mk(4'hF, 4'b1110, 2'd1, 4'b0010);
    rst4 = 1'b1;
    kpr4 = vec[0].kpr;
    q4.push_back(vec[0]);
    repeat (5) @(negedge clk);
    check("dut4_reset", 32'({kpc4, digit4, ct4, tick4, clk4}),
          32'({4'b0111, 2'b00, 4'b0001, 1'b0, 1'b0}));
    rst4 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tick4 && n < 20);
      check("dut4_tick_seen", 32'(tick4), 32'd1);
      @(negedge clk);
      if (i < 16) begin
        kpr4 = vec[i+1].kpr;
        q4.push_back(vec[i+1]);
      end
    end
    @(negedge clk);
    rst4  = 1'b1;
    done4 = 1'b1;
  end

  // Main flow, DIV=1041.
  initial begin
    int n;
    rst1 = 1'b1;
    kpr1 = 4'hF;
    repeat (60) begin
      @(negedge clk);
      check("reset_hold", 32'({kpc1, digit1, ct1, tick1, clk1}),
            32'({4'b0111, 2'b00, 4'b0001, 1'b0, 1'b0}));
    end
    for (int k = 1; k <= 6; k++) tick_exp.push_back(1041 * k);
    edge_exp.push_back(520);
    edge_exp.push_back(1041);
    edge_exp.push_back(1561);
    duty_en = 1'b1;
    rst1    = 1'b0;

    n = 0;
    while (cyc1 < 6846 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("reach_cnt600", 32'(cyc1), 32'd6846);
    check("pre_reset_kpc",   32'(kpc1),   32'b1101);
    check("pre_reset_digit", 32'(digit1), 32'd2);
    check("pre_reset_clk48", 32'(clk1),   32'd1);
    check("ticks_consumed",  32'(tick_exp.size()), 32'd0);
    check("edges_consumed",  32'(edge_exp.size()), 32'd0);
    duty_en = 1'b0;

    #2 rst1 = 1'b1;
    #1 check("reset_async", 32'({kpc1, digit1, ct1, tick1, clk1}),
             32'({4'b0111, 2'b00, 4'b0001, 1'b0, 1'b0}));
    repeat (3) @(negedge clk);
    tick_exp.push_back(1041);
    rst1 = 1'b0;
    repeat (1045) @(negedge clk);
    check("post_reset_tick_consumed", 32'(tick_exp.size()), 32'd0);
    check("post_reset_kpc",   32'(kpc1),   32'b1011);
    check("post_reset_digit", 32'(digit1), 32'd1);
    check("post_reset_ct",    32'(ct1),    32'b0010);

    n = 0;
    while (!done4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("dut4_done", 32'(done4), 32'd1);
    check("dut4_queue_empty", 32'(q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "time limit reached");
  end

endmodule
